// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : program_loader_pkg
// Purpose  : Shared constants for the byte-stream program loader: command and
//            response bytes, FSM state encoding and the count range check.
// Revision : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'

  // Response bytes returned to the transmitter
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // Loader FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LEN_HI = 3'd1;
  localparam state_t ST_LEN_LO = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_ACK    = 3'd5;

  // A load count is usable when it is non-zero and fits the memory depth.
  function automatic logic count_ok(input logic [15:0] count, input int addr_w);
    logic [16:0] limit;
    limit = 17'd1 << addr_w;
    return (count != 16'd0) && ({1'b0, count} <= limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Parses the UART command stream, assembles big-endian 32-bit
//            instruction words, writes them to instruction memory at
//            ascending word addresses and gates the pipeline (run/reset).
// Revision : 1.0 - initial release
// ============================================================================
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              cpu_reset,
  output logic [7:0]        ack_data,
  output logic              ack_valid,
  input  logic              ack_ready,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   c_words_one = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_count_hi;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_words_left;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_shift;
  logic              r_run;
  logic              r_cpu_reset;
  logic [7:0]        r_ack_data;
  logic              r_pending_run;

  logic [15:0]       w_count;
  logic              w_count_ok;
  logic              w_last_word;

  // The full count is only ever needed in the cycle count_lo arrives.
  assign w_count     = {r_count_hi, rx_data};
  assign w_count_ok  = count_ok(w_count, ADDR_W);
  assign w_last_word = (r_words_left == c_words_one);

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; bytes arriving in WRITE or ACK are ignored
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) w_next_state = (rx_data == CMD_LOAD) ? ST_LEN_HI : ST_ACK;
      end
      ST_LEN_HI: begin
        if (rx_valid) w_next_state = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (rx_valid) w_next_state = w_count_ok ? ST_DATA : ST_ACK;
      end
      ST_DATA: begin
        if (rx_valid && (r_byte_cnt == 2'd3)) w_next_state = ST_WRITE;
      end
      ST_WRITE: begin
        w_next_state = w_last_word ? ST_ACK : ST_DATA;
      end
      ST_ACK: begin
        if (ack_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: word assembly, address/word counters, run control, response byte
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count_hi    <= 8'd0;
      r_byte_cnt    <= 2'd0;
      r_words_left  <= '0;
      r_addr        <= '0;
      r_shift       <= 32'd0;
      r_run         <= RUN_ON_RESET;
      r_cpu_reset   <= 1'b0;
      r_ack_data    <= 8'd0;
      r_pending_run <= 1'b0;
    end else begin
      r_cpu_reset <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_LOAD) begin
              // Freeze the pipeline while its program is being replaced
              r_run         <= 1'b0;
              r_addr        <= '0;
              r_pending_run <= 1'b0;
            end else if (rx_data == CMD_RUN) begin
              r_run      <= 1'b1;
              r_ack_data <= RSP_ACK;
            end else if (rx_data == CMD_STOP) begin
              r_run      <= 1'b0;
              r_ack_data <= RSP_ACK;
            end else begin
              r_ack_data <= RSP_NAK;
            end
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) r_count_hi <= rx_data;
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            r_byte_cnt   <= 2'd0;
            r_words_left <= (ADDR_W+1)'(w_count);
            if (!w_count_ok) r_ack_data <= RSP_NAK;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            // First byte of the word ends up in the MSBs
            r_shift    <= {r_shift[23:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        ST_WRITE: begin
          r_addr       <= r_addr + c_addr_one;
          r_words_left <= r_words_left - c_words_one;
          if (w_last_word) begin
            r_ack_data    <= RSP_ACK;
            r_pending_run <= 1'b1;
          end
        end
        ST_ACK: begin
          // Release the pipeline from a clean reset once the host saw the ACK
          if (ack_ready && r_pending_run) begin
            r_run         <= 1'b1;
            r_cpu_reset   <= 1'b1;
            r_pending_run <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    imem_we   = (r_state == ST_WRITE);
    ack_valid = (r_state == ST_ACK);
    busy      = (r_state != ST_IDLE);
  end

  assign imem_addr  = r_addr;
  assign imem_wdata = r_shift;
  assign cpu_run    = r_run;
  assign cpu_reset  = r_cpu_reset;
  assign ack_data   = r_ack_data;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Randomized self-checking bench for program_loader. A protocol
//            level model queues the expected memory writes and response
//            bytes; a negedge compare process checks them as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              cpu_reset;
  logic [7:0]        ack_data;
  logic              ack_valid;
  logic              ack_ready;
  logic              busy;

  program_loader #(.ADDR_W(ADDR_W), .RUN_ON_RESET(1'b0)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .cpu_reset  (cpu_reset),
    .ack_data   (ack_data),
    .ack_valid  (ack_valid),
    .ack_ready  (ack_ready),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Model state
  wr_t        exp_wr[$];
  logic [7:0] exp_ack[$];
  bit         exp_run;

  // Observations made by the compare process
  int                hs_count     = 0;
  int                reset_pulses = 0;
  int                write_count  = 0;
  logic [ADDR_W-1:0] last_addr    = '0;
  logic [31:0]       last_data    = 32'd0;
  logic              prev_valid   = 1'b0;
  logic              prev_hs      = 1'b0;
  logic              prev_run     = 1'b0;
  logic [7:0]        prev_data    = 8'd0;
  wr_t               cur_wr;

  logic [31:0] wq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: every write, every handshake, ack stability, cpu_reset
  always @(negedge clock) begin
    if (!reset) begin
      if (imem_we) begin
        write_count++;
        last_addr = imem_addr;
        last_data = imem_wdata;
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          cur_wr = exp_wr.pop_front();
          check("write_addr", 32'(imem_addr), 32'(cur_wr.addr));
          check("write_data", imem_wdata, cur_wr.data);
        end
      end
      if (prev_valid && !prev_hs) begin
        check("ack_valid_hold", 32'(ack_valid), 32'd1);
        check("ack_data_hold", 32'(ack_data), 32'(prev_data));
      end
      if (ack_valid && ack_ready) begin
        hs_count++;
        if (exp_ack.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
        else                     check("ack_data", 32'(ack_data), 32'(exp_ack.pop_front()));
      end
      if (cpu_reset) begin
        reset_pulses++;
        check("cpu_reset_with_run", 32'(cpu_run), 32'd1);
        check("cpu_reset_first_run_cycle", 32'(prev_run), 32'd0);
      end
    end
    prev_valid = ack_valid;
    prev_hs    = ack_valid && ack_ready;
    prev_data  = ack_data;
    prev_run   = cpu_run;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    tick($urandom_range(1, 3));
  endtask

  task automatic wait_ack(input int start);
    int n;
    n = 0;
    if (!ack_ready) begin
      tick($urandom_range(0, 5));
      ack_ready = 1'b1;
    end
    while (hs_count == start && n < 300) begin
      tick(1);
      n++;
    end
    check("ack_within_budget", 32'(hs_count != start), 32'd1);
    tick(1);
  endtask

  task automatic check_idle();
    check("cpu_run", 32'(cpu_run), 32'(exp_run));
    check("busy_after_txn", 32'(busy), 32'd0);
    check("writes_drained", 32'(exp_wr.size()), 32'd0);
    check("acks_drained", 32'(exp_ack.size()), 32'd0);
  endtask

  // Single-byte command: R / S / anything other than L
  task automatic cmd(input logic [7:0] b);
    int start;
    start     = hs_count;
    ack_ready = 1'($urandom_range(0, 1));
    exp_ack.push_back((b == CMD_RUN || b == CMD_STOP) ? RSP_ACK : RSP_NAK);
    if (b == CMD_RUN)  exp_run = 1'b1;
    if (b == CMD_STOP) exp_run = 1'b0;
    send_byte(b);
    wait_ack(start);
    check_idle();
  endtask

  // Load command; data words are sent only for a count the host believes valid
  task automatic load(input logic [15:0] count, input logic [31:0] words[$]);
    int start, pulses;
    bit ok;
    wr_t w;
    start     = hs_count;
    pulses    = reset_pulses;
    ok        = (count >= 16'd1) && (int'(count) <= DEPTH);
    ack_ready = 1'($urandom_range(0, 1));
    exp_run   = 1'b0;
    if (ok) begin
      for (int i = 0; i < int'(count); i++) begin
        w.addr = ADDR_W'(i);
        w.data = words[i];
        exp_wr.push_back(w);
      end
      exp_ack.push_back(RSP_ACK);
    end else begin
      exp_ack.push_back(RSP_NAK);
    end
    send_byte(CMD_LOAD);
    send_byte(count[15:8]);
    send_byte(count[7:0]);
    if (ok) begin
      for (int i = 0; i < int'(count); i++)
        for (int j = 0; j < 4; j++)
          send_byte(words[i][31-8*j -: 8]);
    end
    wait_ack(start);
    if (ok) exp_run = 1'b1;
    check("cpu_reset_pulses", 32'(reset_pulses - pulses), ok ? 32'd1 : 32'd0);
    check_idle();
  endtask

  task automatic check_reset_values();
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_ack_valid", 32'(ack_valid), 32'd0);
    check("rst_ack_data", 32'(ack_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    rx_data   = 8'd0;
    rx_valid  = 1'b0;
    ack_ready = 1'b1;
    exp_run   = 1'b0;
    tick(3);
    check_reset_values();
    reset = 1'b0;
    tick(2);

    // Two-word load from the worked example
    wq = {32'h20010005, 32'h8C020000};
    load(16'd2, wq);
    check("pin_write_count", 32'(write_count), 32'd2);
    check("pin_last_addr", 32'(last_addr), 32'd1);
    check("pin_last_data", last_data, 32'h8C020000);
    check("pin_run_after_load", 32'(cpu_run), 32'd1);

    // Out-of-range counts
    wq = {};
    load(16'h0000, wq);
    load(16'h0401, wq);
    check("pin_no_write_on_nak", 32'(write_count), 32'd2);

    // Stop / run / unknown
    cmd(CMD_STOP);
    check("pin_stopped", 32'(cpu_run), 32'd0);
    cmd(CMD_RUN);
    check("pin_running", 32'(cpu_run), 32'd1);
    cmd(8'h41);
    check("pin_run_unchanged", 32'(cpu_run), 32'd1);

    // Response held 20 cycles while the host keeps sending bytes
    begin
      int start;
      start     = hs_count;
      ack_ready = 1'b0;
      exp_ack.push_back(RSP_ACK);
      exp_run = 1'b0;
      send_byte(CMD_STOP);
      for (int k = 0; k < 10; k++) begin
        rx_data  = 8'($urandom);
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(1);
      end
      check("ack_still_valid", 32'(ack_valid), 32'd1);
      check("ack_held_byte", 32'(ack_data), 32'(RSP_ACK));
      ack_ready = 1'b1;
      wait_ack(start);
      check_idle();
      cmd(CMD_RUN);
    end

    // Reset in the middle of a two-word load: first word already written
    begin
      wr_t w;
      exp_run = 1'b0;
      w.addr  = '0;
      w.data  = 32'h11223344;
      exp_wr.push_back(w);
      send_byte(CMD_LOAD);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66);
      reset = 1'b1;
      tick(2);
      check_reset_values();
      check("mid_load_first_word_written", 32'(exp_wr.size()), 32'd0);
      reset = 1'b0;
      tick(2);
      wq = {32'hCAFEF00D};
      load(16'd1, wq);
      check("pin_reload_addr", 32'(last_addr), 32'd0);
    end

    // Randomized mix of loads and commands
    for (int it = 0; it < 14; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        int n;
        n  = $urandom_range(1, 6);
        wq = {};
        for (int i = 0; i < n; i++) wq.push_back($urandom);
        load(16'(n), wq);
      end else if (op == 1) begin
        logic [7:0] b;
        case ($urandom_range(0, 2))
          0: b = CMD_RUN;
          1: b = CMD_STOP;
          default: begin
            b = 8'($urandom);
            while (b == CMD_LOAD) b = 8'($urandom);
          end
        endcase
        cmd(b);
      end else begin
        wq = {};
        if ($urandom_range(0, 1) == 0) load(16'h0000, wq);
        else load(16'($urandom_range(DEPTH + 1, 65535)), wq);
      end
    end

    // Full-depth load, data equals address
    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back(32'(i));
    load(16'(DEPTH), wq);
    check("pin_full_last_addr", 32'(last_addr), 32'h3FF);
    check("pin_full_last_data", last_data, 32'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard time limit so the run can never hang
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Byte-stream program loader for the MIPS/DLX pipeline. It parses a simple command protocol arriving from a UART receiver, assembles big-endian 32-bit instruction words and writes them into instruction memory at ascending addresses. It also gates the pipeline through `cpu_run` and `cpu_reset`. It is the writer side of the instruction memory that `instruction_fetch` reads, and it sits between the UART and the CPU top.

## Interface
- `ADDR_W`, default 10: instruction memory address width, matching the 10-bit PC.
- `RUN_ON_RESET`, default 0: value of `cpu_run` after reset.
- `clock` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `rx_data` input, 8 bits: received byte.
- `rx_valid` input, 1 bit: one-cycle strobe; `rx_data` is valid in that cycle.
- `imem_we` output, 1 bit: instruction memory write strobe, one cycle.
- `imem_addr` output, ADDR_W bits: write address, in words.
- `imem_wdata` output, 32 bits: write data.
- `cpu_run` output, 1 bit: pipeline enable; 0 freezes the pipeline.
- `cpu_reset` output, 1 bit: one-cycle pulse to the pipeline reset after a successful load.
- `ack_data` output, 8 bits: response byte to the UART transmitter.
- `ack_valid` output, 1 bit: response available.
- `ack_ready` input, 1 bit: transmitter accepts; a transfer occurs when `ack_valid` and `ack_ready` are both 1.
- `busy` output, 1 bit: 1 in any state other than IDLE.

## Operation
- Commands are accepted only in IDLE:
  - 0x4C 'L': load.
  - 0x52 'R': run. Sets `cpu_run`=1 and sends ACK 0x06.
  - 0x53 'S': stop. Sets `cpu_run`=0 and sends ACK 0x06.
  - Any other byte: send NAK 0x15; `cpu_run` is unchanged.
- Load sequence: 'L', count_hi, count_lo, then count×4 data bytes, MSB first. count is 16 bits and must satisfy 1 ≤ count ≤ 2^ADDR_W.
  - count out of range: send NAK 0x15 and return to IDLE; no memory write occurs.
- Accepting 'L' forces `cpu_run`=0 in the same clock edge.
- FSM states and transitions:
  - IDLE –'L'→ LEN_HI
  - LEN_HI → LEN_LO
  - LEN_LO –valid count→ DATA
  - LEN_LO –bad count→ ACK (NAK byte)
  - DATA: collects 4 bytes in a 2-bit byte counter; on the 4th byte → WRITE
  - WRITE: `imem_we`=1 for one cycle; address increments; words_left decrements. Goes to DATA if words_left ≠ 0, else to ACK with 0x06 and a pending-run flag.
  - ACK: holds `ack_valid` until handshake, then → IDLE. If the pending-run flag is set, the handshake cycle also sets `cpu_run`=1 and pulses `cpu_reset`.
- Address starts at 0 on every 'L' and increments after each write. The maximum count ends at address 2^ADDR_W−1, so no wrap is possible.
- `rx_valid` arriving in WRITE or ACK: the byte is dropped, with no state effect. The protocol is host-paced, one byte per ≥10 cycles, so WRITE never collides in practice; the drop rule is normative.
- `ack_data`/`ack_valid` stay stable while waiting for `ack_ready`.
- `imem_wdata` = {b0,b1,b2,b3}, with b0 being the first byte received of the word.

## Timing
- Reset values:
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0
  - `cpu_run`=RUN_ON_RESET, `cpu_reset`=0
  - `ack_valid`=0, `ack_data`=0, `busy`=0
  - state IDLE
- Write latency: `imem_we` is asserted in the cycle after the clock edge that captured the 4th byte.
- ACK latency: `ack_valid` rises in the cycle after the clock edge that completed the last write, or that captured a command byte (R, S, unknown) or count_lo (bad count).
- `cpu_reset` is high for exactly one cycle, coincident with the first cycle of `cpu_run`=1 after a load.
- `reset` mid-load: abort immediately and return to reset values. Words already written stay in memory.
- `ack_ready` held high: handshake completes in the first `ack_valid` cycle.

## Structure
- Shared package holds:
  - command byte constants: CMD_LOAD 0x4C, CMD_RUN 0x52, CMD_STOP 0x53
  - response constants: RSP_ACK 0x06, RSP_NAK 0x15
  - FSM state encoding (3 bits)
- Single module with no sub-modules. Word assembly is a 32-bit shift register inside the FSM block.

## Test plan
- 'L',0x00,0x02, bytes 20 01 00 05 8C 02 00 00 → writes 0x20010005 @0 and 0x8C020000 @1. Then after `ack_ready`: ack 0x06, `cpu_run`=1, and one `cpu_reset` pulse.
- 'L',0x00,0x00 → NAK 0x15, no `imem_we`. Same for 'L',0x04,0x01 with ADDR_W=10.
- 'S' then 'R' → `cpu_run` 1→0 then 0→1, each followed by ack 0x06. Byte 0x41 → NAK, `cpu_run` unchanged.
- `ack_ready` held low for 20 cycles during ACK while `rx_valid` pulses → `ack_valid`/`ack_data` stable, bytes dropped, state returns to IDLE after handshake.
- `reset` after 6 data bytes of a 2-word load → all outputs at reset values. A following 1-word load writes at address 0.
- Full 1024-word load with pattern data=address → last write at `imem_addr`=0x3FF, followed by ACK.
